// File: rtl/fir_pkg.sv
// Shared definitions for the FIR engine: FSM state encodings, the default tap
// count and the circular-history address helpers.
// Optional build macro used by this slice: FIR_SAT_EN (saturating MAC in fir_mac).
package fir_pkg;

    // Default number of taps / history entries.
    localparam int FIR_NTAP_DEF = 11;

    // Internal index width for counters and circular pointers, wider than any
    // realistic tap count so the wrap arithmetic never overflows.
    localparam int FIR_IDX_W = 16;
    typedef logic [FIR_IDX_W-1:0] fir_idx_t;

    localparam fir_idx_t FIR_IDX_ZERO = 16'd0;
    localparam fir_idx_t FIR_IDX_ONE  = 16'd1;

    // FSM state encodings.
    typedef logic [2:0] fir_state_t;
    localparam fir_state_t ST_IDLE    = 3'd0;
    localparam fir_state_t ST_CLEAR   = 3'd1;
    localparam fir_state_t ST_WAIT_IN = 3'd2;
    localparam fir_state_t ST_MAC     = 3'd3;
    localparam fir_state_t ST_OUT     = 3'd4;
    localparam fir_state_t ST_DONE    = 3'd5;

    // (base - off) mod modn, for base < modn and off <= modn.
    function automatic fir_idx_t fir_wrap_sub(input fir_idx_t base,
                                              input fir_idx_t off,
                                              input fir_idx_t modn);
        fir_idx_t res;
        if (base >= off) begin
            res = base - off;
        end else begin
            res = base + modn - off;
        end
        return res;
    endfunction

    // (ptr + 1) mod modn, for ptr < modn.
    function automatic fir_idx_t fir_wrap_inc(input fir_idx_t ptr,
                                              input fir_idx_t modn);
        fir_idx_t res;
        if (ptr == (modn - FIR_IDX_ONE)) begin
            res = FIR_IDX_ZERO;
        end else begin
            res = ptr + FIR_IDX_ONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath of the FIR engine.
// Default build: signed BIT_WIDTH product truncated to BIT_WIDTH, accumulator
// wraps modulo 2^BIT_WIDTH.
// With FIR_SAT_EN defined: full-precision product, 2*BIT_WIDTH+4 bit
// accumulator and a result saturated to the signed BIT_WIDTH range.
// Timing is identical in both builds: clr and en act on the next clock edge.
module fir_mac
    import fir_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [BIT_WIDTH-1:0] tap,
    input  logic [BIT_WIDTH-1:0] dat,
    output logic [BIT_WIDTH-1:0] result
);

`ifdef FIR_SAT_EN
    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam int ACC_W  = 2 * BIT_WIDTH + 4;

    localparam logic signed [BIT_WIDTH-1:0] OUT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [BIT_WIDTH-1:0] OUT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0]     ACC_MAX = ACC_W'(OUT_MAX);
    localparam logic signed [ACC_W-1:0]     ACC_MIN = ACC_W'(OUT_MIN);
    localparam logic signed [ACC_W-1:0]     ACC_ZERO = {ACC_W{1'b0}};

    logic signed [PROD_W-1:0] tap_x_s;
    logic signed [PROD_W-1:0] dat_x_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  acc_r;
    logic [BIT_WIDTH-1:0]     result_s;

    // Operands are sign-extended first so the product keeps full precision.
    assign tap_x_s = PROD_W'($signed(tap));
    assign dat_x_s = PROD_W'($signed(dat));
    assign prod_s  = tap_x_s * dat_x_s;

    // Wide accumulator: cleared on reset or at the start of each output sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= ACC_ZERO;
        end else if (clr) begin
            acc_r <= ACC_ZERO;
        end else if (en) begin
            acc_r <= acc_r + ACC_W'(prod_s);
        end
    end

    // Clamp the wide sum into the signed output range.
    always_comb begin
        result_s = acc_r[BIT_WIDTH-1:0];
        if (acc_r > ACC_MAX) begin
            result_s = OUT_MAX;
        end else if (acc_r < ACC_MIN) begin
            result_s = OUT_MIN;
        end else begin
            result_s = acc_r[BIT_WIDTH-1:0];
        end
    end

    assign result = result_s;
`else
    localparam logic signed [BIT_WIDTH-1:0] ACC_ZERO = {BIT_WIDTH{1'b0}};

    logic signed [BIT_WIDTH-1:0] prod_s;
    logic signed [BIT_WIDTH-1:0] acc_r;
    logic [BIT_WIDTH-1:0]        result_s;

    // A BIT_WIDTH x BIT_WIDTH product in a BIT_WIDTH context keeps the low bits.
    assign prod_s = $signed(tap) * $signed(dat);

    // Wrapping accumulator: cleared on reset or at the start of each output sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= ACC_ZERO;
        end else if (clr) begin
            acc_r <= ACC_ZERO;
        end else if (en) begin
            acc_r <= acc_r + prod_s;
        end
    end

    // Result is the raw accumulator, modulo 2^BIT_WIDTH.
    always_comb begin
        result_s = acc_r;
    end

    assign result = result_s;
`endif

endmodule

// File: rtl/fir_engine.sv
// FIR filter engine: streams samples in, keeps an NTAP-deep circular history
// in an external data BRAM, multiplies against taps held in an external tap
// BRAM, and streams one filtered value out per input sample.
// Optional build macro: FIR_SAT_EN (saturating accumulation inside fir_mac).
// Reset is synchronous and active-high; BRAM contents are not touched by reset,
// the CLEAR state zeroes the history at the start of every run instead.
module fir_engine
    import fir_pkg::*;
#(
    parameter int NTAP       = FIR_NTAP_DEF,
    parameter int ADDR_WIDTH = 12,
    parameter int BIT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ap_start,
    input  logic [31:0]           data_length,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic                  ss_tvalid,
    input  logic [BIT_WIDTH-1:0]  ss_tdata,
    output logic                  ss_tready,
    output logic                  sm_tvalid,
    output logic [BIT_WIDTH-1:0]  sm_tdata,
    output logic                  sm_tlast,
    input  logic                  sm_tready,
    output logic                  tap_re,
    output logic [ADDR_WIDTH-1:0] tap_raddr,
    input  logic [BIT_WIDTH-1:0]  tap_rdo,
    output logic                  dat_we,
    output logic [ADDR_WIDTH-1:0] dat_waddr,
    output logic [BIT_WIDTH-1:0]  dat_wdi,
    output logic                  dat_re,
    output logic [ADDR_WIDTH-1:0] dat_raddr,
    input  logic [BIT_WIDTH-1:0]  dat_rdo
);

    localparam fir_idx_t              NTAP_I    = fir_idx_t'(NTAP);
    localparam fir_idx_t              NTAP_M1   = fir_idx_t'(NTAP - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [BIT_WIDTH-1:0]  DATA_ZERO = {BIT_WIDTH{1'b0}};

    // FSM and bookkeeping
    fir_state_t state_r;
    fir_state_t state_nx_s;
    fir_idx_t   cnt_r;          // CLEAR address index / MAC cycle index
    fir_idx_t   cnt_nx_s;
    fir_idx_t   wptr_r;         // history slot of the newest sample
    logic [31:0] count_r;       // samples fully emitted this run
    logic [31:0] len_r;         // run length captured at start
    logic        ss_hs_s;
    logic        sm_hs_s;
    logic        last_s;
    logic        rd_en_nx_s;
    logic        acc_clr_s;
    logic        acc_en_s;
    logic [BIT_WIDTH-1:0] mac_result_s;

    // Registered outputs
    logic                  ap_idle_r;
    logic                  ap_done_r;
    logic                  ss_tready_r;
    logic                  sm_tvalid_r;
    logic [BIT_WIDTH-1:0]  sm_tdata_r;
    logic                  sm_tlast_r;
    logic                  rd_en_r;
    logic [ADDR_WIDTH-1:0] tap_raddr_r;
    logic [ADDR_WIDTH-1:0] dat_raddr_r;
    logic                  clr_we_r;
    logic [ADDR_WIDTH-1:0] clr_addr_r;

    // Data BRAM write port (must act in the handshake cycle itself)
    logic                  dat_we_s;
    logic [ADDR_WIDTH-1:0] dat_waddr_s;
    logic [BIT_WIDTH-1:0]  dat_wdi_s;

    assign ss_hs_s = ss_tvalid & ss_tready_r;
    assign sm_hs_s = sm_tvalid_r & sm_tready;
    assign last_s  = ((count_r + 32'd1) == len_r);

    // Next-state and cycle-counter logic.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (ap_start) begin
                    state_nx_s = ST_CLEAR;
                    cnt_nx_s   = FIR_IDX_ZERO;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_r == NTAP_M1) begin
                    state_nx_s = (len_r == 32'd0) ? ST_DONE : ST_WAIT_IN;
                    cnt_nx_s   = FIR_IDX_ZERO;
                end else begin
                    cnt_nx_s   = cnt_r + FIR_IDX_ONE;
                end
            end
            ST_WAIT_IN: begin
                if (ss_hs_s) begin
                    state_nx_s = ST_MAC;
                    cnt_nx_s   = FIR_IDX_ZERO;
                end else begin
                    state_nx_s = ST_WAIT_IN;
                end
            end
            ST_MAC: begin
                // NTAP read cycles plus one to absorb the BRAM read latency.
                if (cnt_r == NTAP_I) begin
                    state_nx_s = ST_OUT;
                    cnt_nx_s   = FIR_IDX_ZERO;
                end else begin
                    cnt_nx_s   = cnt_r + FIR_IDX_ONE;
                end
            end
            ST_OUT: begin
                if (sm_hs_s) begin
                    state_nx_s = sm_tlast_r ? ST_DONE : ST_WAIT_IN;
                end else begin
                    state_nx_s = ST_OUT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = FIR_IDX_ZERO;
            end
        endcase
    end

    // BRAM reads are issued for MAC cycles 0..NTAP-1 only.
    always_comb begin
        if ((state_nx_s == ST_MAC) && (cnt_nx_s < NTAP_I)) begin
            rd_en_nx_s = 1'b1;
        end else begin
            rd_en_nx_s = 1'b0;
        end
    end

    // State, run length, history pointer and sample count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= FIR_IDX_ZERO;
            wptr_r  <= FIR_IDX_ZERO;
            count_r <= 32'd0;
            len_r   <= 32'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            if ((state_r == ST_IDLE) && ap_start) begin
                len_r <= data_length;
            end
            if (state_r == ST_CLEAR) begin
                wptr_r  <= FIR_IDX_ZERO;
                count_r <= 32'd0;
            end else if ((state_r == ST_OUT) && sm_hs_s) begin
                wptr_r  <= fir_wrap_inc(wptr_r, NTAP_I);
                count_r <= count_r + 32'd1;
            end
        end
    end

    // Control outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ap_idle_r   <= 1'b1;
            ap_done_r   <= 1'b0;
            ss_tready_r <= 1'b0;
            clr_we_r    <= 1'b0;
            clr_addr_r  <= ADDR_ZERO;
            rd_en_r     <= 1'b0;
            tap_raddr_r <= ADDR_ZERO;
            dat_raddr_r <= ADDR_ZERO;
        end else begin
            ap_idle_r   <= (state_nx_s == ST_IDLE);
            ap_done_r   <= (state_nx_s == ST_DONE);
            ss_tready_r <= (state_nx_s == ST_WAIT_IN);
            clr_we_r    <= (state_nx_s == ST_CLEAR);
            clr_addr_r  <= (state_nx_s == ST_CLEAR) ? ADDR_WIDTH'(cnt_nx_s) : ADDR_ZERO;
            rd_en_r     <= rd_en_nx_s;
            // Tap k pairs with the sample k steps older than the newest one.
            tap_raddr_r <= rd_en_nx_s ? ADDR_WIDTH'(cnt_nx_s) : ADDR_ZERO;
            dat_raddr_r <= rd_en_nx_s ? ADDR_WIDTH'(fir_wrap_sub(wptr_r, cnt_nx_s, NTAP_I))
                                      : ADDR_ZERO;
        end
    end

    // Output stream: the first OUT cycle captures the result, then it is held
    // until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sm_tvalid_r <= 1'b0;
            sm_tdata_r  <= DATA_ZERO;
            sm_tlast_r  <= 1'b0;
        end else if (state_r == ST_OUT) begin
            if (sm_hs_s) begin
                sm_tvalid_r <= 1'b0;
                sm_tdata_r  <= DATA_ZERO;
                sm_tlast_r  <= 1'b0;
            end else if (!sm_tvalid_r) begin
                sm_tvalid_r <= 1'b1;
                sm_tdata_r  <= mac_result_s;
                sm_tlast_r  <= last_s;
            end
        end
    end

    // Data BRAM write port: zero fill during CLEAR, else the accepted sample.
    always_comb begin
        dat_we_s    = 1'b0;
        dat_waddr_s = ADDR_ZERO;
        dat_wdi_s   = DATA_ZERO;
        if (clr_we_r) begin
            dat_we_s    = 1'b1;
            dat_waddr_s = clr_addr_r;
            dat_wdi_s   = DATA_ZERO;
        end else if (ss_hs_s) begin
            dat_we_s    = 1'b1;
            dat_waddr_s = ADDR_WIDTH'(wptr_r);
            dat_wdi_s   = ss_tdata;
        end else begin
            dat_we_s    = 1'b0;
            dat_waddr_s = ADDR_ZERO;
            dat_wdi_s   = DATA_ZERO;
        end
    end

    // Accumulator restarts on MAC entry; read data arrives one cycle after
    // its address, so accumulation runs in MAC cycles 1..NTAP.
    assign acc_clr_s = (state_r == ST_WAIT_IN) && ss_hs_s;
    assign acc_en_s  = (state_r == ST_MAC) && (cnt_r != FIR_IDX_ZERO);

    fir_mac #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr_s),
        .en     (acc_en_s),
        .tap    (tap_rdo),
        .dat    (dat_rdo),
        .result (mac_result_s)
    );

    assign ap_idle   = ap_idle_r;
    assign ap_done   = ap_done_r;
    assign ss_tready = ss_tready_r;
    assign sm_tvalid = sm_tvalid_r;
    assign sm_tdata  = sm_tdata_r;
    assign sm_tlast  = sm_tlast_r;
    assign tap_re    = rd_en_r;
    assign tap_raddr = tap_raddr_r;
    assign dat_re    = rd_en_r;
    assign dat_raddr = dat_raddr_r;
    assign dat_we    = dat_we_s;
    assign dat_waddr = dat_waddr_s;
    assign dat_wdi   = dat_wdi_s;

endmodule

// File: tb/tb_fir_engine.sv
// Directed testbench for fir_engine with simple 1-cycle-latency BRAM models.
module tb_fir_engine;

    localparam int NTAP = 11;
    localparam int AW   = 12;
    localparam int BW   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ap_start;
    logic [31:0]   data_length;
    logic          ap_idle;
    logic          ap_done;
    logic          ss_tvalid;
    logic [BW-1:0] ss_tdata;
    logic          ss_tready;
    logic          sm_tvalid;
    logic [BW-1:0] sm_tdata;
    logic          sm_tlast;
    logic          sm_tready;
    logic          tap_re;
    logic [AW-1:0] tap_raddr;
    logic [BW-1:0] tap_rdo;
    logic          dat_we;
    logic [AW-1:0] dat_waddr;
    logic [BW-1:0] dat_wdi;
    logic          dat_re;
    logic [AW-1:0] dat_raddr;
    logic [BW-1:0] dat_rdo;

    logic [BW-1:0] tap_mem [0:(1<<AW)-1];
    logic [BW-1:0] dat_mem [0:(1<<AW)-1];

    int n_vec = 0;
    int n_bad = 0;

    fir_engine #(
        .NTAP       (NTAP),
        .ADDR_WIDTH (AW),
        .BIT_WIDTH  (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ap_start    (ap_start),
        .data_length (data_length),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .ss_tvalid   (ss_tvalid),
        .ss_tdata    (ss_tdata),
        .ss_tready   (ss_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tdata    (sm_tdata),
        .sm_tlast    (sm_tlast),
        .sm_tready   (sm_tready),
        .tap_re      (tap_re),
        .tap_raddr   (tap_raddr),
        .tap_rdo     (tap_rdo),
        .dat_we      (dat_we),
        .dat_waddr   (dat_waddr),
        .dat_wdi     (dat_wdi),
        .dat_re      (dat_re),
        .dat_raddr   (dat_raddr),
        .dat_rdo     (dat_rdo)
    );

    always #5 clk = ~clk;

    // BRAM models: registered read, synchronous write.
    always @(posedge clk) begin
        if (tap_re) tap_rdo <= tap_mem[tap_raddr];
        if (dat_re) dat_rdo <= dat_mem[dat_raddr];
        if (dat_we) dat_mem[dat_waddr] <= dat_wdi;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_run(input int len);
        data_length = 32'(len);
        ap_start    = 1'b1;
        @(negedge clk);
        ap_start    = 1'b0;
    endtask

    // Feed one sample, check latency, value, tlast, optional stall, then accept.
    task automatic push_one(input string tag, input logic [31:0] smp, input logic [31:0] exp,
                            input logic last, input int stall);
        int t;
        t = 0;
        while (!ss_tready && t < 64) begin @(negedge clk); t++; end
        chk({tag, "/ss_tready"}, 32'(ss_tready), 32'd1);
        ss_tvalid = 1'b1;
        ss_tdata  = smp;
        @(posedge clk);
        @(negedge clk);
        ss_tvalid = 1'b0;
        ss_tdata  = 32'd0;
        t = 0;
        while (!sm_tvalid && t < 64) begin @(negedge clk); t++; end
        chk({tag, "/latency"}, 32'(t), 32'd13);
        chk({tag, "/data"}, sm_tdata, exp);
        chk({tag, "/last"}, 32'(sm_tlast), 32'(last));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "/stall_data"}, sm_tdata, exp);
            chk({tag, "/stall_valid"}, 32'(sm_tvalid), 32'd1);
            chk({tag, "/stall_ready"}, 32'(ss_tready), 32'd0);
        end
        sm_tready = 1'b1;
        @(negedge clk);
        sm_tready = 1'b0;
        chk({tag, "/valid_drop"}, 32'(sm_tvalid), 32'd0);
        chk({tag, "/done"}, 32'(ap_done), 32'(last));
        if (last) begin
            @(negedge clk);
            chk({tag, "/done_end"}, 32'(ap_done), 32'd0);
            chk({tag, "/idle_end"}, 32'(ap_idle), 32'd1);
        end
    endtask

    task automatic run_seq(input string tag, input int len, input logic [31:0] din[$],
                           input logic [31:0] dexp[$], input int stall_at);
        start_run(len);
        chk({tag, "/busy"}, 32'(ap_idle), 32'd0);
        for (int i = 0; i < len; i++) begin
            push_one($sformatf("%s[%0d]", tag, i), din[i], dexp[i], (i == len - 1),
                     (i == stall_at) ? 5 : 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] din[$];
        logic [31:0] dexp[$];
        int t;
        logic seen_valid;

        rst = 1'b1; ap_start = 1'b0; data_length = 32'd0;
        ss_tvalid = 1'b0; ss_tdata = 32'd0; sm_tready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst/ap_idle", 32'(ap_idle), 32'd1);
        chk("rst/ap_done", 32'(ap_done), 32'd0);
        chk("rst/ss_tready", 32'(ss_tready), 32'd0);
        chk("rst/sm_tvalid", 32'(sm_tvalid), 32'd0);
        chk("rst/sm_tdata", sm_tdata, 32'd0);
        chk("rst/tap_re", 32'(tap_re), 32'd0);
        chk("rst/dat_re", 32'(dat_re), 32'd0);
        chk("rst/dat_we", 32'(dat_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Step with history wrap, backpressure on sample 3
        for (int k = 0; k < NTAP; k++) tap_mem[k] = 32'd1;
        din.delete(); dexp.delete();
        for (int i = 0; i < 15; i++) begin
            din.push_back(32'd2);
            dexp.push_back(32'(2 * ((i + 1 < NTAP) ? (i + 1) : NTAP)));
        end
        run_seq("step", 15, din, dexp, 3);

        // Impulse: leftover history of 2s must have been cleared
        for (int k = 0; k < NTAP; k++) tap_mem[k] = 32'(k + 1);
        din.delete(); dexp.delete();
        for (int i = 0; i < NTAP; i++) begin
            din.push_back((i == 0) ? 32'd1 : 32'd0);
            dexp.push_back(32'(i + 1));
        end
        run_seq("imp", NTAP, din, dexp, -1);

        // Zero-length run
        start_run(0);
        chk("len0/clr_we", 32'(dat_we), 32'd1);
        chk("len0/clr_addr", 32'(dat_waddr), 32'd0);
        t = 1;
        seen_valid = 1'b0;
        while (!ap_done && t < 64) begin
            @(negedge clk);
            t++;
            if (sm_tvalid) seen_valid = 1'b1;
        end
        chk("len0/done_delay", 32'(t), 32'(NTAP + 1));
        chk("len0/no_valid", 32'(seen_valid), 32'd0);
        @(negedge clk);
        chk("len0/done_pulse", 32'(ap_done), 32'd0);
        chk("len0/idle", 32'(ap_idle), 32'd1);

        // Reset in the middle of MAC
        start_run(NTAP);
        t = 0;
        while (!ss_tready && t < 64) begin @(negedge clk); t++; end
        chk("rstmac/ss_tready", 32'(ss_tready), 32'd1);
        ss_tvalid = 1'b1; ss_tdata = 32'd5;
        @(posedge clk);
        @(negedge clk);
        ss_tvalid = 1'b0; ss_tdata = 32'd0;
        repeat (4) @(negedge clk);
        chk("rstmac/tap_re", 32'(tap_re), 32'd1);
        chk("rstmac/tap_raddr", 32'(tap_raddr), 32'd4);
        chk("rstmac/dat_raddr", 32'(dat_raddr), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmac/ap_idle", 32'(ap_idle), 32'd1);
        chk("rstmac/tap_re_off", 32'(tap_re), 32'd0);
        chk("rstmac/dat_re_off", 32'(dat_re), 32'd0);
        chk("rstmac/tap_raddr_off", 32'(tap_raddr), 32'd0);
        chk("rstmac/sm_tvalid", 32'(sm_tvalid), 32'd0);
        chk("rstmac/ss_tready_off", 32'(ss_tready), 32'd0);
        run_seq("imp2", NTAP, din, dexp, -1);

        // Extreme operands: saturation or wrap
        for (int k = 0; k < NTAP; k++) tap_mem[k] = 32'h7FFF_FFFF;
        din.delete(); dexp.delete();
        din.push_back(32'h7FFF_FFFF);
`ifdef FIR_SAT_EN
        dexp.push_back(32'h7FFF_FFFF);
`else
        dexp.push_back(32'h0000_0001);
`endif
        run_seq("big", 1, din, dexp, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
